thermo_expand: RTL and testbench

- Inverse of the popcount stage. Takes a count k and streams a DW-bit thermometer hypervector whose popcount is exactly min(k, DW).
- Bits 0..k-1 are set; all others are clear.
- Used for HDC level-vector generation and for popcount round-trip checks.
- The vector leaves as DW/CW chunks over a valid/ready stream, so wide vectors never exist as one flat bus.

---
 rtl/thermo_pkg.sv | 26 ++
 rtl/thermo_chunk.sv | 16 +
 rtl/thermo_popcount.sv | 17 +
 rtl/thermo_expand.sv | 113 +++++++++++
 tb/tb_thermo_expand.sv | 152 +++++++++++++++
 5 files changed

// File: rtl/thermo_pkg.sv
// rtl/thermo_pkg.sv - shared state encoding and width helpers for thermo_expand
package thermo_pkg;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    SEND = 1'b1
  } state_e;

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_SEND = 1'b1;

  function automatic int nch(input int dw, input int cw);
    return dw / cw;
  endfunction

  function automatic int idx_w(input int dw, input int cw);
    int n;
    n = dw / cw;
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  function automatic int cnt_w(input int dw);
    return $clog2(dw + 1);
  endfunction

endpackage

// File: rtl/thermo_chunk.sv
// rtl/thermo_chunk.sv - combinational saturated mask: bit i set when i < rem
module thermo_chunk
  import thermo_pkg::*;
#(
  parameter int CW   = 64,
  parameter int CNTW = 11
) (
  input  logic [CNTW-1:0] rem,
  output logic [CW-1:0]   mask
);

  for (genvar i = 0; i < CW; i++) begin : g_bit
    assign mask[i] = (rem > CNTW'(i));
  end

endmodule

// File: rtl/thermo_popcount.sv
// rtl/thermo_popcount.sv - combinational popcount of a W-bit word
module thermo_popcount #(
  parameter int W  = 64,
  parameter int PW = $clog2(W + 1)
) (
  input  logic [W-1:0]  data,
  output logic [PW-1:0] count
);

  always_comb begin
    count = '0;
    for (int i = 0; i < W; i++) begin
      count = count + PW'(data[i]);
    end
  end

endmodule

// File: rtl/thermo_expand.sv
// rtl/thermo_expand.sv - count to chunked thermometer vector stream
// Optional sticky round-trip self-check enabled by THERMO_EXPAND_CHECK_EN.
module thermo_expand
  import thermo_pkg::*;
#(
  parameter int DW   = 1024,
  parameter int CW   = 64,
  parameter int CNTW = $clog2(DW + 1)
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      cnt_valid,
  output logic                      cnt_ready,
  input  logic [CNTW-1:0]           cnt,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [CW-1:0]             out_data,
  output logic [idx_w(DW,CW)-1:0]   out_idx,
  output logic                      out_last,
  output logic                      chk_err
);

  localparam int NB = nch(DW, CW);
  localparam int IW = idx_w(DW, CW);

  logic [0:0]      state;
  logic [CNTW-1:0] rem;
  logic [CNTW-1:0] cnt_sat;
  logic [CW-1:0]   mask;
  logic            beat_fire;

  assign cnt_sat   = (cnt > CNTW'(DW)) ? CNTW'(DW) : cnt;
  assign cnt_ready = (state == ST_IDLE);
  assign out_valid = (state == ST_SEND);
  assign out_last  = out_valid && (out_idx == IW'(NB - 1));
  assign beat_fire = out_valid && out_ready;

  thermo_chunk #(.CW(CW), .CNTW(CNTW)) u_chunk (
    .rem  (rem),
    .mask (mask)
  );

  // Gate with state so the data bus reads zero whenever no beat is offered.
  assign out_data = out_valid ? mask : '0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= ST_IDLE;
      rem     <= '0;
      out_idx <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (cnt_valid) begin
            rem     <= cnt_sat;
            out_idx <= '0;
            state   <= ST_SEND;
          end
        end
        ST_SEND: begin
          if (out_ready) begin
            rem <= (rem > CNTW'(CW)) ? rem - CNTW'(CW) : '0;
            if (out_last) begin
              out_idx <= '0;
              state   <= ST_IDLE;
            end else begin
              out_idx <= out_idx + IW'(1);
            end
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

`ifdef THERMO_EXPAND_CHECK_EN
  localparam int PW = $clog2(CW + 1);

  logic [PW-1:0]   beat_pc;
  logic [CNTW-1:0] acc;
  logic [CNTW-1:0] kreq;
  logic            err_q;

  thermo_popcount #(.W(CW), .PW(PW)) u_pc (
    .data  (out_data),
    .count (beat_pc)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc   <= '0;
      kreq  <= '0;
      err_q <= 1'b0;
    end else if (cnt_valid && cnt_ready) begin
      acc  <= '0;
      kreq <= cnt_sat;
    end else if (beat_fire) begin
      if (out_last) begin
        if (acc + CNTW'(beat_pc) != kreq) begin
          err_q <= 1'b1;
        end
      end else begin
        acc <= acc + CNTW'(beat_pc);
      end
    end
  end

  assign chk_err = err_q;
`else
  assign chk_err = 1'b0;
`endif

endmodule

// File: tb/tb_thermo_expand.sv
// tb/tb_thermo_expand.sv - randomized self-checking bench for thermo_expand (DW=256, CW=64)
module tb_thermo_expand;

  localparam int DW   = 256;
  localparam int CW   = 64;
  localparam int CNTW = 9;
  localparam int NB   = 4;

  logic            clk;
  logic            rst_n;
  logic            cnt_valid;
  logic            cnt_ready;
  logic [CNTW-1:0] cnt;
  logic            out_valid;
  logic            out_ready;
  logic [CW-1:0]   out_data;
  logic [1:0]      out_idx;
  logic            out_last;
  logic            chk_err;

  int total;
  int bad;

  thermo_expand #(.DW(DW), .CW(CW), .CNTW(CNTW)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .cnt_valid (cnt_valid),
    .cnt_ready (cnt_ready),
    .cnt       (cnt),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_idx   (out_idx),
    .out_last  (out_last),
    .chk_err   (chk_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference: whole vector bit b is set exactly when b < min(k, DW).
  function automatic logic [63:0] model_beat(input int k, input int j);
    int km;
    logic [63:0] r;
    km = (k > DW) ? DW : k;
    for (int i = 0; i < CW; i++) r[i] = ((j * CW + i) < km);
    return r;
  endfunction

  // mode: 0 always ready, 1 toggle 1/0, 2 random. hold_next >= 0 keeps a request queued.
  task automatic run_vec(input int k, input int mode, input int hold_next);
    int nb;
    int cyc;
    logic rdy;
    check("idle_cnt_ready", 64'(cnt_ready), 64'd1);
    cnt_valid = 1'b1;
    cnt = CNTW'(k);
    @(negedge clk);
    if (hold_next >= 0) cnt = CNTW'(hold_next);
    else cnt_valid = 1'b0;
    check("first_beat_latency", 64'(out_valid), 64'd1);
    nb = 0;
    cyc = 0;
    while (nb < NB && cyc < 200) begin
      case (mode)
        0:       rdy = 1'b1;
        1:       rdy = (cyc % 2 == 0);
        default: rdy = 1'($urandom % 2);
      endcase
      out_ready = rdy;
      if (hold_next >= 0) check("cnt_ready_busy", 64'(cnt_ready), 64'd0);
      check("out_valid", 64'(out_valid), 64'd1);
      check("out_data", out_data, model_beat(k, nb));
      check("out_idx", 64'(out_idx), 64'(nb));
      check("out_last", 64'(out_last), 64'(nb == NB - 1));
      if (rdy) nb++;
      cyc++;
      @(negedge clk);
    end
    if (nb < NB) check("beat_timeout", 64'(nb), 64'(NB));
    out_ready = 1'b0;
    check("bubble_out_valid", 64'(out_valid), 64'd0);
    check("bubble_cnt_ready", 64'(cnt_ready), 64'd1);
    check("chk_err", 64'(chk_err), 64'd0);
  endtask

  initial begin
    total = 0;
    bad = 0;
    rst_n = 1'b0;
    cnt_valid = 1'b0;
    cnt = '0;
    out_ready = 1'b0;
    #12;
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_cnt_ready", 64'(cnt_ready), 64'd1);
    check("rst_out_data", out_data, 64'd0);
    check("rst_out_idx", 64'(out_idx), 64'd0);
    check("rst_out_last", 64'(out_last), 64'd0);
    check("rst_chk_err", 64'(chk_err), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    run_vec(0, 0, -1);
    run_vec(100, 0, -1);
    run_vec(256, 0, -1);
    run_vec(300, 0, -1);
    run_vec(70, 1, -1);
    run_vec(130, 0, 5);
    run_vec(5, 0, -1);

    // Abandon k=200 while beat 2 is on the bus.
    check("pre_abort_ready", 64'(cnt_ready), 64'd1);
    cnt_valid = 1'b1;
    cnt = CNTW'(200);
    @(negedge clk);
    cnt_valid = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    @(negedge clk);
    check("abort_beat2_idx", 64'(out_idx), 64'd2);
    check("abort_beat2_data", out_data, model_beat(200, 2));
    rst_n = 1'b0;
    #1;
    check("abort_valid_drop", 64'(out_valid), 64'd0);
    check("abort_idx_clear", 64'(out_idx), 64'd0);
    check("abort_data_clear", out_data, 64'd0);
    out_ready = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("post_abort_valid", 64'(out_valid), 64'd0);
    run_vec(64, 0, -1);

    for (int t = 0; t < 30; t++) begin
      run_vec(int'($urandom_range(0, 300)), int'($urandom_range(0, 2)), -1);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
